// File: rtl/cnn_acc_pkg.sv
// Shared types, default widths and saturation helpers for the CNN accelerator datapath.
package cnn_acc_pkg;

  localparam int unsigned PsumWidth = 16;
  localparam int unsigned AccWidth  = 24;
  localparam int unsigned OutWidth  = 8;
  localparam int unsigned Depth     = 16;
  localparam int unsigned Shift     = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDrain = 2'd2
  } acc_state_t;

  // Clamp a wide signed value to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v,
                                                 input int unsigned w);
    return sat_to(v, w);
  endfunction

  function automatic logic signed [63:0] sat_out(input logic signed [63:0] v,
                                                 input int unsigned w);
    return sat_to(v, w);
  endfunction

endpackage

// File: rtl/psum_acc_buffer_if.sv
// Tile-control, psum input and drain handshake bundle of psum_acc_buffer.
interface psum_acc_buffer_if
  import cnn_acc_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH = PsumWidth,
  parameter int unsigned OUT_WIDTH  = OutWidth
);
  logic                         start;
  logic [7:0]                   num_pass;
  logic                         psum_valid;
  logic signed [PSUM_WIDTH-1:0] psum_in;
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_last;
  logic                         done;

  modport master (
    output start, num_pass, psum_valid, psum_in, out_ready,
    input  busy, out_valid, out_data, out_last, done
  );

  modport slave (
    input  start, num_pass, psum_valid, psum_in, out_ready,
    output busy, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/psum_requant.sv
// Combinational requantizer: arithmetic shift, optional ReLU, output saturation.
// ReLU is enabled by defining PSUM_ACC_RELU_EN.
module psum_requant
  import cnn_acc_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = AccWidth,
  parameter int unsigned OUT_WIDTH = OutWidth,
  parameter int unsigned SHIFT     = Shift
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic signed [OUT_WIDTH-1:0] o_data
);
  logic signed [63:0] w_shift;
  logic signed [63:0] w_rect;

  always_comb begin
    w_shift = 64'(i_acc) >>> SHIFT;
`ifdef PSUM_ACC_RELU_EN
    w_rect = (w_shift < 64'sd0) ? 64'sd0 : w_shift;
`else
    w_rect = w_shift;
`endif
    o_data = OUT_WIDTH'(sat_out(w_rect, OUT_WIDTH));
  end
endmodule

// File: rtl/psum_acc_buffer.sv
// Accumulates a PE column's psum stream over several passes, then drains requantized results.
// Define PSUM_ACC_RELU_EN to clamp negative outputs to zero.
module psum_acc_buffer
  import cnn_acc_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH = PsumWidth,
  parameter int unsigned ACC_WIDTH  = AccWidth,
  parameter int unsigned OUT_WIDTH  = OutWidth,
  parameter int unsigned DEPTH      = Depth,
  parameter int unsigned SHIFT      = Shift
) (
  input logic                clk,
  input logic                rst_n,
  psum_acc_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  acc_state_t                  r_state;
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [7:0]                  r_pass_cnt;
  logic [7:0]                  r_num_pass;
  logic                        r_done;
  logic signed [ACC_WIDTH-1:0] r_buf [DEPTH];

  logic                        w_wr_en;
  logic                        w_wrap;
  logic                        w_last_pass;
  logic                        w_accept;
  logic                        w_rd_last;
  logic signed [63:0]          w_sum;
  logic signed [ACC_WIDTH-1:0] w_new;
  logic signed [ACC_WIDTH-1:0] w_rd_acc;
  logic signed [OUT_WIDTH-1:0] w_req;

  always_comb begin
    w_wr_en     = (r_state == StAccum) && bus.psum_valid;
    w_wrap      = (r_wr_ptr == AW'(DEPTH - 1));
    w_last_pass = (r_pass_cnt == r_num_pass - 8'd1);
    w_accept    = (r_state == StDrain) && bus.out_ready;
    w_rd_last   = (r_rd_ptr == AW'(DEPTH - 1));
    w_sum       = 64'(r_buf[r_wr_ptr]) + 64'(bus.psum_in);
    // First pass overwrites, so stale data from a previous tile never leaks in.
    if (r_pass_cnt == 8'd0) w_new = ACC_WIDTH'(64'(bus.psum_in));
    else                    w_new = ACC_WIDTH'(sat_acc(w_sum, ACC_WIDTH));
    w_rd_acc    = r_buf[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pass_cnt <= '0;
      r_num_pass <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state    <= StAccum;
            r_num_pass <= (bus.num_pass == 8'd0) ? 8'd1 : bus.num_pass;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pass_cnt <= '0;
          end
        end
        StAccum: begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_wrap) begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
              if (w_last_pass) r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (w_accept) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_rd_last) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  psum_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_requant (
    .i_acc  (w_rd_acc),
    .o_data (w_req)
  );

  assign bus.busy      = (r_state != StIdle);
  assign bus.out_valid = (r_state == StDrain);
  assign bus.out_data  = (r_state == StDrain) ? w_req : '0;
  assign bus.out_last  = (r_state == StDrain) && w_rd_last;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_psum_acc_buffer.sv
// Self-checking bench for psum_acc_buffer (DEPTH=4, SHIFT=2); honours PSUM_ACC_RELU_EN.
module tb_psum_acc_buffer;
  logic clk;
  logic rst_n;

  psum_acc_buffer_if #(.PSUM_WIDTH(16), .OUT_WIDTH(8)) bus ();

  psum_acc_buffer #(
    .PSUM_WIDTH (16),
    .ACC_WIDTH  (24),
    .OUT_WIDTH  (8),
    .DEPTH      (4),
    .SHIFT      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       np;
    logic             gaps;
    logic             bp;
    logic             poke;
    logic [3:0][15:0] ps;
    logic [3:0][7:0]  ex;
  } vec_t;

  vec_t vt [8];
  int   exp_q [$];
  int   n_vec;
  int   n_err;

  function automatic int relu(input int x);
`ifdef PSUM_ACC_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic vec_t mk(input int np, input bit g, input bit b, input bit p,
                              input int a0, input int a1, input int a2, input int a3,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.np = np[7:0]; v.gaps = g; v.bp = b; v.poke = p;
    v.ps[0] = a0[15:0]; v.ps[1] = a1[15:0]; v.ps[2] = a2[15:0]; v.ps[3] = a3[15:0];
    v.ex[0] = relu(e0) & 8'hff; v.ex[1] = relu(e1) & 8'hff;
    v.ex[2] = relu(e2) & 8'hff; v.ex[3] = relu(e3) & 8'hff;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_tile(input vec_t v);
    int eff;
    int acc;
    int cyc;
    bit have_stall;
    int stall_data;
    int stall_last;
    int e;
    eff = (v.np == 8'd0) ? 1 : int'(v.np);
    for (int k = 0; k < 4; k++) exp_q.push_back(int'($signed(v.ex[k])));
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_pass = v.np;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.num_pass = 8'd0;
    @(negedge clk);
    chk("busy_after_start", int'(bus.busy), 1);
    for (int p = 0; p < eff; p++) begin
      for (int k = 0; k < 4; k++) begin
        bus.psum_valid = 1'b1;
        bus.psum_in    = v.ps[k];
        if (v.poke && p == 0 && k == 2) begin
          bus.start = 1'b1; bus.num_pass = 8'd5;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.num_pass = 8'd0;
        if (v.gaps) begin
          bus.psum_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    bus.psum_valid = 1'b0;
    @(negedge clk);
    chk("valid_after_last_write", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    acc = 0; cyc = 0; have_stall = 1'b0; stall_data = 0; stall_last = 0;
    while (acc < 4 && cyc < 64) begin
      bus.out_ready = v.bp ? cyc[0] : 1'b1;
      @(negedge clk);
      if (bus.out_valid) begin
        if (have_stall) begin
          chk("hold_data", int'(bus.out_data), stall_data);
          chk("hold_last", int'(bus.out_last), stall_last);
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
            e = 0;
          end else begin
            e = exp_q.pop_front();
          end
          chk("out_data", int'(bus.out_data), e);
          chk("out_last", int'(bus.out_last), (acc == 3) ? 1 : 0);
          acc++;
          have_stall = 1'b0;
        end else begin
          have_stall = 1'b1;
          stall_data = int'(bus.out_data);
          stall_last = int'(bus.out_last);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (acc < 4) chk("drain_timeout_accepts", acc, 4);
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 1);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("valid_after_done", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    int seen_done;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.num_pass = 8'd0; bus.psum_valid = 1'b0;
    bus.psum_in = '0; bus.out_ready = 1'b0;

    vt[0] = mk(1,   0, 0, 0, 4, 8, -12, 400, 1, 2, -3, 100);
    vt[1] = mk(3,   1, 0, 0, 10, 20, 30, 40, 7, 15, 22, 30);
    vt[2] = mk(255, 0, 0, 0, 32767, 32767, 32767, 32767, 127, 127, 127, 127);
    vt[3] = mk(255, 0, 0, 0, -32768, -32768, -32768, -32768, -128, -128, -128, -128);
    vt[4] = mk(1,   0, 1, 0, 4, 8, -12, 400, 1, 2, -3, 100);
    vt[5] = mk(0,   0, 0, 0, 4, 8, -12, 400, 1, 2, -3, 100);
    vt[6] = mk(2,   0, 1, 0, -5, 3, 1000, -1000, -3, 1, 127, -128);
    vt[7] = mk(2,   0, 0, 1, 10, 20, 30, 40, 5, 10, 15, 20);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    rst_n = 1'b1;

    // psum_valid while idle must not touch the buffer or state
    @(posedge clk); #1;
    bus.psum_valid = 1'b1; bus.psum_in = 16'sd999;
    @(posedge clk); #1;
    bus.psum_valid = 1'b0;
    @(negedge clk);
    chk("idle_ignores_psum", int'(bus.busy), 0);

    for (int i = 0; i < 8; i++) run_tile(vt[i]);

    // Reset mid-drain: aborts the tile without a done pulse.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_pass = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.psum_valid = 1'b1; bus.psum_in = 16'sd100;
      @(posedge clk); #1;
    end
    bus.psum_valid = 1'b0;
    @(negedge clk);
    chk("abort_valid_before_rst", int'(bus.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid_async", int'(bus.out_valid), 0);
    chk("abort_busy_async", int'(bus.busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);

    run_tile(vt[1]);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
